// File: rtl/vga_link_tx.sv
`timescale 1ns/1ps
// Purpose: serialises one char/colour byte or row select per handshake onto the 4-wire display link (wclk, d0, dc, cs).
// Latency: accept-to-ready is 19*CLK_DIV cycles for a char and 17*CLK_DIV for a row; the resync frame after reset is 19*CLK_DIV.
// Backpressure: cmd_ready is high only in IDLE; a pending command waits on cmd_valid until the current frame completes.
module vga_link_tx #(
  parameter int CLK_DIV       = 2,
  parameter int SYNC_ON_RESET = 1
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_is_row,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       wclk,
  output logic       d0,
  output logic       dc,
  output logic       cs
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    SYNC   = 3'd0,
    IDLE   = 3'd1,
    BIT_LO = 3'd2,
    BIT_HI = 3'd3,
    LAT_LO = 3'd4,
    LAT_HI = 3'd5,
    GAP    = 3'd6
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_payload, w_payload_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [2:0]    r_last, w_last_nxt;
  logic          r_wclk;
  logic          r_d0, w_d0_nxt;
  logic          r_dc, w_dc_nxt;
  logic          r_cs, w_cs_nxt;
  logic          w_half_done;
  logic [2:0]    w_idx_inc;

  assign w_half_done = (r_cnt == HALF_LAST);
  assign w_idx_inc   = r_idx + 3'd1;

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign wclk      = r_wclk;
  assign d0        = r_d0;
  assign dc        = r_dc;
  assign cs        = r_cs;

  // State and link registers; reset parks the link quiet and optionally queues the resync frame
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      r_state   <= (SYNC_ON_RESET != 0) ? SYNC : IDLE;
      r_cnt     <= '0;
      r_payload <= '0;
      r_idx     <= '0;
      r_last    <= 3'd7;
      r_wclk    <= 1'b0;
      r_d0      <= 1'b0;
      r_dc      <= 1'b0;
      r_cs      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_payload <= w_payload_nxt;
      r_idx     <= w_idx_nxt;
      r_last    <= w_last_nxt;
      // wclk is high exactly in the two "HI" states, so it is a pure function of the next state
      r_wclk    <= (w_state_nxt == BIT_HI) || (w_state_nxt == LAT_HI);
      r_d0      <= w_d0_nxt;
      r_dc      <= w_dc_nxt;
      r_cs      <= w_cs_nxt;
    end
  end

  // Next-state and next-output logic; d0/dc/cs only move on transitions into a wclk-low state
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_payload_nxt = r_payload;
    w_idx_nxt     = r_idx;
    w_last_nxt    = r_last;
    w_d0_nxt      = r_d0;
    w_dc_nxt      = r_dc;
    w_cs_nxt      = r_cs;

    case (r_state)
      SYNC: begin
        // eight zero bits on the row stream flush the receiver's row shifter and bit counter
        w_payload_nxt = 8'h00;
        w_last_nxt    = 3'd7;
        w_idx_nxt     = 3'd0;
        w_cs_nxt      = 1'b0;
        w_dc_nxt      = 1'b1;
        w_d0_nxt      = 1'b0;
        w_state_nxt   = BIT_LO;
      end
      IDLE: begin
        if (cmd_valid) begin
          w_payload_nxt = cmd_is_row ? {1'b0, cmd_data[6:0]} : cmd_data;
          w_last_nxt    = cmd_is_row ? 3'd6 : 3'd7;
          w_idx_nxt     = 3'd0;
          w_cs_nxt      = ~cmd_is_row;
          w_dc_nxt      = 1'b1;
          w_d0_nxt      = cmd_data[0];
          w_state_nxt   = BIT_LO;
        end
      end
      BIT_LO: begin
        if (w_half_done) w_state_nxt = BIT_HI;
      end
      BIT_HI: begin
        if (w_half_done) begin
          if (r_idx != r_last) begin
            w_idx_nxt   = w_idx_inc;
            w_d0_nxt    = r_payload[w_idx_inc];
            w_state_nxt = BIT_LO;
          end else begin
            w_dc_nxt    = 1'b0;
            w_d0_nxt    = 1'b0;
            w_state_nxt = LAT_LO;
          end
        end
      end
      LAT_LO: begin
        if (w_half_done) w_state_nxt = LAT_HI;
      end
      LAT_HI: begin
        if (w_half_done) w_state_nxt = GAP;
      end
      GAP: begin
        if (w_half_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // half-period counter restarts on every state change; IDLE is untimed
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (r_state != IDLE) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

endmodule
